// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped countdown timer that raises the CPU's external interrupt.
// It sits on the data-memory bridge, decoded on addr[31:4] == ADDR_BASE[31:4].
//
// Register map (addr[3:2] selects, addr[1:0] ignored):
//   0x0 CTRL   : [0] EN, [2:1] MODE, [3] IM (1 = interrupt allowed), rest 0
//   0x4 PRESET : 32-bit reload value, read/write
//   0x8 COUNT  : 32-bit current count, read-only (writes dropped)
//   0xC        : reads 0
//
// Modes: MODE 01 auto-reload (irq is a one-cycle pulse per expiry);
//        MODE 00/10/11 one-shot (EN self-clears, irq held until CTRL write).
//
// Ports:
//   clk    in   1 : clock, all state changes on the rising edge
//   reset  in   1 : synchronous active-high reset
//   addr   in  32 : byte address from the bridge
//   we     in   1 : word write strobe
//   din    in  32 : write data
//   dout   out 32 : combinational read data of the addressed register
//   irq    out  1 : interrupt request, irq_flag gated by CTRL.IM
//
// Bus access: there is no handshake and no stall. Every cycle in which addr
// hits the block is an access; with we=1 the register is written at the next
// rising edge, and dout always reflects the currently addressed register.
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO  = 2'b01;

    // Architectural state. `state` is kept as a named enum so it is visible
    // by name in waveforms and to bound checkers.
    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    // Next-state values produced by the combinational process.
    state_t      state_next;
    logic [3:0]  ctrl_next;
    logic [31:0] preset_next;
    logic [31:0] count_next;
    logic        flag_next;
    logic        en_clear;

    // Decoded bus signals.
    logic        hit;
    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;

    // CTRL fields.
    logic        en;
    logic [1:0]  mode;
    logic        im;

    // Byte-lane address bits carry no information for word registers.
    logic        unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[1:0]};

    assign hit       = (addr[31:4] == ADDR_BASE[31:4]);
    assign sel       = addr[3:2];
    assign wr_ctrl   = we && hit && (sel == REG_CTRL);
    assign wr_preset = we && hit && (sel == REG_PRESET);

    assign en   = ctrl[0];
    assign mode = ctrl[2:1];
    assign im   = ctrl[3];

    assign irq  = irq_flag & im;

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    always_comb begin
        dout = 32'd0;
        if (hit) begin
            case (sel)
                REG_CTRL:   dout = {28'd0, ctrl};
                REG_PRESET: dout = preset;
                REG_COUNT:  dout = count;
                default:    dout = 32'd0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_next;
            ctrl     <= ctrl_next;
            preset   <= preset_next;
            count    <= count_next;
            irq_flag <= flag_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    //
    // Expiry is declared on the edge whose decrement leaves COUNT at 1 (or
    // immediately when COUNT is already 0 or 1). That makes a PRESET of N>=2
    // expire N-1 edges after the load, and the auto-reload period N+1 cycles
    // (INT -> LOAD -> N-1 counting edges). The INT state then zeroes COUNT.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        count_next = count;
        flag_next  = irq_flag;
        en_clear   = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_next = LOAD;
                end
            end

            LOAD: begin
                count_next = preset;
                state_next = CNT;
            end

            CNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (count <= 32'd2) begin
                    // Saturating step: 2 -> 1, 1 -> 0, 0 stays 0.
                    count_next = (count == 32'd0) ? 32'd0 : count - 32'd1;
                    flag_next  = 1'b1;
                    state_next = INT;
                end else begin
                    count_next = count - 32'd1;
                end
            end

            INT: begin
                count_next = 32'd0;
                if (mode == MODE_AUTO) begin
                    flag_next  = 1'b0;
                    state_next = en ? LOAD : IDLE;
                end else begin
                    // One-shot: the timer disables itself; the flag stays
                    // set until software rewrites CTRL.
                    en_clear   = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        ctrl_next = ctrl;
        if (en_clear) begin
            ctrl_next[0] = 1'b0;
        end
        // A software CTRL write overrides the hardware EN clear in the same
        // cycle and acknowledges any pending interrupt.
        if (wr_ctrl) begin
            ctrl_next = din[3:0];
            flag_next = 1'b0;
        end

        // A PRESET write never disturbs a running count; it is picked up by
        // the next LOAD.
        preset_next = wr_preset ? din : preset;
    end

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//
// Self-checking bench for timer_counter. Expected COUNT / irq / CTRL values
// come from a closed-form timeline model: after the edge that writes EN=1
// (k = 0), each later edge k maps to a phase inside a load/count/expire
// period, and the expected register values follow from plain arithmetic on
// that phase.
// -----------------------------------------------------------------------------
module tb_timer_counter;

    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_PRESET = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;
    localparam logic [31:0] A_OFF    = 32'h0000_7F10;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    timer_counter #(.ADDR_BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model
    //   len  : counting edges between the load and expiry (N-1, at least 1)
    //   one period = LOAD edge + len+1 edges, the last of which is expiry
    // -------------------------------------------------------------------------
    function automatic longint m_len(longint n);
        return (n >= 2) ? n - 1 : 1;
    endfunction

    function automatic longint m_count(int k, longint n, bit auto_mode);
        longint l;
        longint p;
        longint v;
        l = m_len(n);
        if (k <= 0) return 0;
        if (!auto_mode && k >= l + 3) return 0;
        p = auto_mode ? (k - 1) % (l + 2) : longint'(k - 1);
        if (p == 0) return 0;
        v = n - p + 1;
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit m_flag(int k, longint n, bit auto_mode);
        longint l;
        l = m_len(n);
        if (k < 1) return 1'b0;
        if (auto_mode) return ((k - 1) % (l + 2)) == (l + 1);
        return k >= l + 2;
    endfunction

    function automatic bit m_en(int k, longint n, bit auto_mode);
        longint l;
        l = m_len(n);
        if (auto_mode) return 1'b1;
        return k < l + 3;
    endfunction

    // -------------------------------------------------------------------------
    // Driver tasks (all start and end in the low phase of clk)
    // -------------------------------------------------------------------------
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we   = 1'b0;
        din  = 32'd0;
        addr = A_COUNT;
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v    = dout;
        addr = A_COUNT;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] addrs [5];
        addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD, A_OFF};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], v);
            n_checks++;
            if (v !== 32'd0) $display("FAIL reset_read addr=%h got=%h exp=0", addrs[i], v);
            else n_pass++;
        end
        n_checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        logic [31:0] exp_c;
        bit          exp_i;
        do_reset();
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_c = 32'(m_count(k, 5, 1'b0));
            exp_i = m_flag(k, 5, 1'b0);
            n_checks++;
            if (dout !== exp_c) $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, dout, exp_c);
            else n_pass++;
            n_checks++;
            if (irq !== exp_i) $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, irq, exp_i);
            else n_pass++;
        end
        rd(A_CTRL, v);
        n_checks++;
        if (v !== 32'h8) $display("FAIL oneshot_ctrl got=%h exp=8", v);
        else n_pass++;
        wr(A_CTRL, 32'h0);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL oneshot_ack_irq got=%b exp=0", irq);
        else n_pass++;
    endtask

    task automatic test_autoreload();
        logic [31:0] exp_c;
        logic [31:0] hold;
        bit          exp_i;
        do_reset();
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'hB);
        // Edge 14 lands on a LOAD->CNT transition, so the disable leaves the
        // freshly loaded value frozen from then on.
        for (int k = 1; k <= 14; k++) begin
            if (k == 14) wr(A_CTRL, 32'hA);
            else step();
            exp_c = 32'(m_count(k, 3, 1'b1));
            exp_i = m_flag(k, 3, 1'b1);
            n_checks++;
            if (dout !== exp_c) $display("FAIL auto_count k=%0d got=%h exp=%h", k, dout, exp_c);
            else n_pass++;
            n_checks++;
            if (irq !== exp_i) $display("FAIL auto_irq k=%0d got=%b exp=%b", k, irq, exp_i);
            else n_pass++;
        end
        hold = 32'(m_count(14, 3, 1'b1));
        for (int k = 15; k <= 22; k++) begin
            step();
            n_checks++;
            if (dout !== hold) $display("FAIL auto_hold_count k=%0d got=%h exp=%h", k, dout, hold);
            else n_pass++;
            n_checks++;
            if (irq !== 1'b0) $display("FAIL auto_stopped_irq k=%0d got=%b exp=0", k, irq);
            else n_pass++;
        end
    endtask

    task automatic test_masking();
        logic [31:0] v;
        logic [31:0] exp_c;
        do_reset();
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_c = 32'(m_count(k, 2, 1'b0));
            n_checks++;
            if (dout !== exp_c) $display("FAIL mask_count k=%0d got=%h exp=%h", k, dout, exp_c);
            else n_pass++;
            n_checks++;
            if (irq !== 1'b0) $display("FAIL mask_irq k=%0d got=%b exp=0", k, irq);
            else n_pass++;
        end
        rd(A_CTRL, v);
        n_checks++;
        if (v !== 32'h0) $display("FAIL mask_ctrl got=%h exp=0", v);
        else n_pass++;
        wr(A_CTRL, 32'h8);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (irq !== 1'b0) $display("FAIL mask_unmask_irq i=%0d got=%b exp=0", k, irq);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_preset_zero();
        bit exp_i;
        do_reset();
        wr(A_PRESET, 32'd0);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_i = m_flag(k, 0, 1'b0);
            n_checks++;
            if (irq !== exp_i) $display("FAIL zero_irq k=%0d got=%b exp=%b", k, irq, exp_i);
            else n_pass++;
            n_checks++;
            if (dout !== 32'd0) $display("FAIL zero_count k=%0d got=%h exp=0", k, dout);
            else n_pass++;
        end
    endtask

    task automatic test_max_preset();
        logic [31:0] exp_c;
        do_reset();
        wr(A_PRESET, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            // Edge 4 carries a write to COUNT, which must have no effect.
            if (k == 4) wr(A_COUNT, 32'h1234_5678);
            else step();
            exp_c = 32'(m_count(k, 64'h0000_0000_FFFF_FFFF, 1'b0));
            n_checks++;
            if (dout !== exp_c) $display("FAIL max_count k=%0d got=%h exp=%h", k, dout, exp_c);
            else n_pass++;
            n_checks++;
            if (irq !== 1'b0) $display("FAIL max_irq k=%0d got=%b exp=0", k, irq);
            else n_pass++;
        end
    endtask

    task automatic test_preset_update();
        logic [31:0] exp_c;
        bit          exp_i;
        do_reset();
        wr(A_PRESET, 32'd4);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) wr(A_PRESET, 32'd9);
            else step();
            exp_c = 32'(m_count(k, 4, 1'b0));
            exp_i = m_flag(k, 4, 1'b0);
            n_checks++;
            if (dout !== exp_c) $display("FAIL upd_old_count k=%0d got=%h exp=%h", k, dout, exp_c);
            else n_pass++;
            n_checks++;
            if (irq !== exp_i) $display("FAIL upd_old_irq k=%0d got=%b exp=%b", k, irq, exp_i);
            else n_pass++;
        end
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_c = 32'(m_count(k, 9, 1'b0));
            exp_i = m_flag(k, 9, 1'b0);
            n_checks++;
            if (dout !== exp_c) $display("FAIL upd_new_count k=%0d got=%h exp=%h", k, dout, exp_c);
            else n_pass++;
            n_checks++;
            if (irq !== exp_i) $display("FAIL upd_new_irq k=%0d got=%b exp=%b", k, irq, exp_i);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [31:0] exp_c;
        bit          exp_i;
        do_reset();
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            step();
            exp_i = m_flag(k, 2, 1'b0);
            n_checks++;
            if (irq !== exp_i) $display("FAIL b2b_first_irq k=%0d got=%b exp=%b", k, irq, exp_i);
            else n_pass++;
        end
        // Edge 4 is the hardware EN clear; the software write must win.
        wr(A_CTRL, 32'h9);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL b2b_ack_irq got=%b exp=0", irq);
        else n_pass++;
        rd(A_CTRL, v);
        n_checks++;
        if (v !== 32'h9) $display("FAIL b2b_ctrl got=%h exp=9", v);
        else n_pass++;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_c = 32'(m_count(k, 2, 1'b0));
            exp_i = m_flag(k, 2, 1'b0);
            n_checks++;
            if (dout !== exp_c) $display("FAIL b2b_count k=%0d got=%h exp=%h", k, dout, exp_c);
            else n_pass++;
            n_checks++;
            if (irq !== exp_i) $display("FAIL b2b_irq k=%0d got=%b exp=%b", k, irq, exp_i);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic [31:0] exp_c;
        do_reset();
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_c = 32'(m_count(k, 10, 1'b0));
            n_checks++;
            if (dout !== exp_c) $display("FAIL rmid_count k=%0d got=%h exp=%h", k, dout, exp_c);
            else n_pass++;
        end
        do_reset();
        n_checks++;
        if (irq !== 1'b0) $display("FAIL rmid_irq got=%b exp=0", irq);
        else n_pass++;
        rd(A_CTRL, v);
        n_checks++;
        if (v !== 32'h0) $display("FAIL rmid_ctrl got=%h exp=0", v);
        else n_pass++;
        rd(A_PRESET, v);
        n_checks++;
        if (v !== 32'h0) $display("FAIL rmid_preset got=%h exp=0", v);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dout !== 32'd0) $display("FAIL rmid_stopped_count i=%0d got=%h exp=0", k, dout);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [31:0] exp_c;
        logic [31:0] exp_ctrl;
        bit          exp_i;
        int          n;
        logic [1:0]  mode;
        logic        im;
        bit          auto_mode;
        int          cycles;
        for (int it = 0; it < 8; it++) begin
            n         = int'($urandom_range(0, 9));
            mode      = 2'($urandom_range(0, 3));
            im        = 1'($urandom_range(0, 1));
            auto_mode = (mode == 2'b01);
            cycles    = 3 * (int'(m_len(longint'(n))) + 2) + 3;
            do_reset();
            wr(A_PRESET, 32'(n));
            wr(A_CTRL, {28'd0, im, mode, 1'b1});
            for (int k = 1; k <= cycles; k++) begin
                step();
                exp_c = 32'(m_count(k, longint'(n), auto_mode));
                exp_i = m_flag(k, longint'(n), auto_mode) & im;
                n_checks++;
                if (dout !== exp_c)
                    $display("FAIL rand_count it=%0d n=%0d mode=%0d k=%0d got=%h exp=%h",
                             it, n, mode, k, dout, exp_c);
                else n_pass++;
                n_checks++;
                if (irq !== exp_i)
                    $display("FAIL rand_irq it=%0d n=%0d mode=%0d im=%0d k=%0d got=%b exp=%b",
                             it, n, mode, im, k, irq, exp_i);
                else n_pass++;
            end
            exp_ctrl = {28'd0, im, mode, m_en(cycles, longint'(n), auto_mode)};
            rd(A_CTRL, v);
            n_checks++;
            if (v !== exp_ctrl) $display("FAIL rand_ctrl it=%0d got=%h exp=%h", it, v, exp_ctrl);
            else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = A_COUNT;
        din   = 32'd0;
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masking();
        test_preset_zero();
        test_max_preset();
        test_preset_update();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
